// File: rtl/uart_pkg.sv
// uart_pkg: status-word bit positions and transmit sequencer states shared by the UART TX FIFO blocks.
package uart_pkg;
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_ACTIVE    = 3;
    localparam int ST_LEVEL_LSB = 16;
    localparam int ST_LEVEL_W   = 9;
    localparam int ST_ARM_CLR   = 3;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} seq_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: byte-wide circular buffer with registered count; full/empty derive from the count.
module sync_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    // a write into a full buffer is dropped even if a pop frees a slot this cycle
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queues CPU bytes and feeds them to the UART core via load/busy handshake.
// Define UART_TXFIFO_IRQ_EN to enable the transmit-drained interrupt (irq tied low otherwise).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        st_we,
    input  logic [31:0] st_di,
    output logic [31:0] st_do,
    output logic        uart_load,
    output logic [7:0]  uart_data,
    input  logic        uart_busy,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [3:0]  r_tmo;
    logic        r_load;
    logic [7:0]  r_data;
    logic        r_ovf;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic [7:0]  w_head;
    logic        w_acc;
    logic        w_unused;

    assign w_acc    = wr_en && !w_full;
    assign w_unused = ^st_di;

    // the head is popped the cycle after it was latched into uart_data
    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (r_load),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = (!w_empty && !uart_busy) ? LOAD : IDLE;
            LOAD:      w_next = WAIT_BUSY;
            WAIT_BUSY: w_next = uart_busy ? WAIT_DONE :
                                (r_tmo == 4'(BUSY_TIMEOUT - 1)) ? IDLE : WAIT_BUSY;
            WAIT_DONE: w_next = uart_busy ? WAIT_DONE : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tmo   <= '0;
            r_load  <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tmo   <= (r_state == WAIT_BUSY) ? r_tmo + 4'd1 : 4'd0;
            r_load  <= r_state == LOAD;
            r_data  <= (r_state == LOAD) ? w_head : r_data;
            r_ovf   <= (wr_en && w_full) || (r_ovf && !(st_we && st_di[ST_OVF]));
        end
    end

    assign uart_load = r_load;
    assign uart_data = r_data;

    always_comb begin
        st_do = '0;
        st_do[ST_FULL] = w_full;
        st_do[ST_EMPTY] = w_empty;
        st_do[ST_OVF] = r_ovf;
        st_do[ST_ACTIVE] = (r_state != IDLE) || !w_empty;
        st_do[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(w_count);
    end

`ifdef UART_TXFIFO_IRQ_EN
    logic r_armed;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_armed <= w_acc || (r_armed && !(st_we && st_di[ST_ARM_CLR]));
            r_irq   <= w_empty && (r_state == IDLE) && r_armed;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_acc;
    assign w_unused_acc = w_acc;
    assign irq = 1'b0;
`endif
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer between the CPU data-register write path and the UART core's load/busy transmit handshake. CPU byte writes are queued in a FIFO. A small sequencer issues one-cycle load pulses to the UART core whenever it is idle, so software streams bytes without polling busy per byte. Also provides a status word (full/empty/overflow/level) for the CPU register read mux.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- BUSY_TIMEOUT, 4: cycles to wait for uart_busy to rise after a load pulse; 1..15.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle CPU write strobe to the data register.
- wr_data  in  8  byte to enqueue; bits 31:8 of the bus are not connected.
- st_we  in  1  CPU write strobe to the status register.
- st_di  in  32  status write data; bit 2 = 1 clears overflow.
- st_do  out  32  status word: bit0 full, bit1 empty, bit2 overflow (sticky), bit3 tx_active, bits[16+:9] level, rest 0.
- uart_load  out  1  one-cycle load pulse to the UART core.
- uart_data  out  8  byte presented with uart_load, held until the next load.
- uart_busy  in  1  UART core transmit-busy flag.
- irq  out  1  transmit-drained interrupt; see Configuration.

## Operation
- FIFO: circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits, which wrap naturally, plus a count of log2(DEPTH)+1 bits.
- full = (count == DEPTH). empty = (count == 0). Both come from the registered count.
- Write with wr_en=1 and !full: store at wr_ptr, then wr_ptr+1.
- Write with wr_en=1 and full: byte dropped, overflow set. This applies even if a pop happens the same cycle.
- Push and pop in the same cycle: count unchanged.
- Overflow is sticky and is cleared by st_we with st_di[2]=1. If a clear and a new overflow happen in the same cycle, set wins.
- Sequencer states:
  - IDLE: if !empty and !uart_busy, go to LOAD.
  - LOAD: pop the head into uart_data, assert uart_load for one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: if uart_busy, go to WAIT_DONE. If the timeout counter reaches BUSY_TIMEOUT, go to IDLE; the byte is treated as sent.
  - WAIT_DONE: when !uart_busy, go to IDLE.
- tx_active = (state != IDLE) or !empty.

## Timing
- Reset values: uart_load 0, uart_data 0, irq 0, st_do = 0x0000_0002 (empty only). FIFO is flushed, pointers 0, state IDLE, overflow 0.
- Reset mid-transfer: FIFO contents are discarded and the state goes to IDLE. A byte already in the UART shifter still completes on the line; this block does not track it.
- Empty FIFO, IDLE, uart_busy=0, wr_en at edge E0:
  - count=1 after E0.
  - IDLE→LOAD at E1.
  - uart_load=1 and uart_data valid between E2 and E3.
  - The pop occurs at E3.
- Back-to-back bytes: the next load comes no earlier than 2 cycles after uart_busy falls.
- st_do is combinational from registered state, so a read has zero added latency.

## Configuration
- UART_TXFIFO_IRQ_EN defined: irq is a registered level, high while empty and state==IDLE and an "armed" flag is set.
  - Armed is set by any accepted write.
  - Armed is cleared by st_we with st_di[3]=1 and by rst.
- Not defined: irq is tied to 0 and the armed logic is absent. st_di[3] is ignored.

## Structure
- Shared package uart_pkg holds:
  - status bit-index constants (ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_ACTIVE=3, ST_LEVEL_LSB=16);
  - the sequencer state encoding {IDLE, LOAD, WAIT_BUSY, WAIT_DONE}.
- One sub-module: sync_fifo, holding storage, pointers, count, full and empty. uart_tx_fifo holds the sequencer, overflow and irq logic.

## Test plan
- Reset, then write 0x41 with uart_busy=0: uart_load is exactly one pulse, 2 cycles after the write edge, with uart_data=0x41. empty=1 afterwards.
- BFM raises busy 1 cycle after load and holds it 80 cycles. Write 0x01..0x05: loads carry bytes in order. Each load occurs only after busy has fallen. level decrements 5→0.
- Fill 16 bytes with busy held high, then write 0xEE: full=1, overflow=1, level=16, 0xEE is never transmitted. st_we with st_di=0x4 clears overflow.
- Full FIFO, then push and pop in the same cycle: push dropped, overflow set, count becomes 15.
- uart_busy never rises after a load: return to IDLE after BUSY_TIMEOUT=4 cycles, and the next byte loads normally.
- With UART_TXFIFO_IRQ_EN, write 2 bytes, let them drain: irq rises once the state is IDLE and empty. st_di=0x8 drops irq. Rst mid-stream: queued bytes are never loaded and irq=0.
